// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the sort frame buffer.
package sort_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DIM_DEFAULT   = 4;
  localparam int WIDTH_DEFAULT = 8;

  // Width of a counter that indexes 0..dim-1, never narrower than one bit.
  function automatic int cnt_width(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/bubble_sort.sv
// Combinational bubble-sort network: DIM-1 full passes of adjacent
// compare-and-swap, so the output is fully ascending (slot 0 = smallest).
// Packing: element i occupies bits [WIDTH*(i+1)-1 : WIDTH*i].
module bubble_sort #(
  parameter int DIM   = 4,
  parameter int WIDTH = 8
) (
  input  logic [DIM*WIDTH-1:0] data_in,
  output logic [DIM*WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] elem [DIM];
  logic [WIDTH-1:0] tmp;

  // Unpack, run the unsigned compare-swap passes, repack.
  always_comb begin
    tmp      = '0;
    data_out = '0;
    for (int i = 0; i < DIM; i++) begin
      elem[i] = data_in[i*WIDTH +: WIDTH];
    end
    for (int p = 0; p < DIM-1; p++) begin
      for (int j = 0; j < DIM-1-p; j++) begin
        if (elem[j] > elem[j+1]) begin
          tmp       = elem[j];
          elem[j]   = elem[j+1];
          elem[j+1] = tmp;
        end
      end
    end
    for (int i = 0; i < DIM; i++) begin
      data_out[i*WIDTH +: WIDTH] = elem[i];
    end
  end

endmodule

// File: rtl/sort_frame_buffer.sv
// Stream wrapper around bubble_sort: gathers DIM elements from a
// valid/ready input, iterates the sorter until its output is a fixed point,
// then streams the ascending frame out, smallest element first.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   FILL  | accepting input beats into frame_q[cnt]; in_ready high
//   SORT  | frame_q <= S(frame_q) each cycle until stable or watchdog
//   DRAIN | presenting frame_q[cnt] on the output port; input stalled
//
// All handshake outputs are flops updated alongside the state, so there is
// no combinational path from any valid input to any ready output.
module sort_frame_buffer
  import sort_pkg::*;
#(
  parameter int DIM   = DIM_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int               CNT_W = cnt_width(DIM);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIM-1);

  state_t                     state;
  logic     [CNT_W-1:0]       cnt;
  logic     [CNT_W-1:0]       iter;
  logic     [CNT_W-1:0]       nxt_cnt;
  logic     [WIDTH-1:0]       frame_q  [DIM];
  logic     [WIDTH-1:0]       sorted_u [DIM];
  logic     [DIM*WIDTH-1:0]   frame_pk;
  logic     [DIM*WIDTH-1:0]   sorted_pk;
  logic                       fixed_pt;

  bubble_sort #(
    .DIM   (DIM),
    .WIDTH (WIDTH)
  ) u_sort (
    .data_in  (frame_pk),
    .data_out (sorted_pk)
  );

  // Pack the frame for the sorter and unpack its result; detect the fixed point.
  always_comb begin
    frame_pk = '0;
    for (int i = 0; i < DIM; i++) begin
      frame_pk[i*WIDTH +: WIDTH] = frame_q[i];
      sorted_u[i]                = sorted_pk[i*WIDTH +: WIDTH];
    end
    fixed_pt = (sorted_pk == frame_pk);
    nxt_cnt  = cnt + 1'b1;
  end

  // Frame FSM with counters, frame storage and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      cnt       <= '0;
      iter      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < DIM; i++) begin
        frame_q[i] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            frame_q[cnt] <= in_data;
            if (cnt == LAST) begin
              cnt      <= '0;
              state    <= SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              cnt <= nxt_cnt;
            end
          end
        end

        SORT: begin
          for (int i = 0; i < DIM; i++) begin
            frame_q[i] <= sorted_u[i];
          end
          iter <= iter + 1'b1;
          // The watchdog bounds SORT to DIM cycles even if the sorter never settles.
          if (fixed_pt || (iter == LAST)) begin
            iter      <= '0;
            state     <= DRAIN;
            out_valid <= 1'b1;
            out_data  <= sorted_u[0];
            out_last  <= 1'b0;
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (cnt == LAST) begin
              cnt       <= '0;
              state     <= FILL;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              cnt      <= nxt_cnt;
              out_data <= frame_q[nxt_cnt];
              out_last <= (nxt_cnt == LAST);
            end
          end
        end

        default: begin
          state     <= FILL;
          cnt       <= '0;
          iter      <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_frame_buffer.sv
// Directed bench for sort_frame_buffer: a DIM=4 instance for the directed
// frames and a DIM=5 instance checked against a software sort.
module tb_sort_frame_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic [7:0] in_data4, out_data4;
  logic       in_valid4, in_ready4, out_valid4, out_ready4, out_last4, busy4;

  logic [7:0] in_data5, out_data5;
  logic       in_valid5, in_ready5, out_valid5, out_ready5, out_last5, busy5;

  int n_pass = 0;
  int n_chk  = 0;

  logic [7:0] got4 [4];
  logic       gl4  [4];
  int         sort_cyc4;

  logic [7:0] v5 [5];
  logic [7:0] s5 [5];
  logic [7:0] e4 [4];
  logic [7:0] d4 [4];

  sort_frame_buffer #(.DIM(4), .WIDTH(8)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_last  (out_last4),
    .busy      (busy4)
  );

  sort_frame_buffer #(.DIM(5), .WIDTH(8)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data5),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .out_data  (out_data5),
    .out_valid (out_valid5),
    .out_ready (out_ready5),
    .out_last  (out_last5),
    .busy      (busy5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [7:0] d);
    int t;
    t = 0;
    in_valid4 = 1'b1;
    in_data4  = d;
    while (in_ready4 !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("push4_timeout", {31'd0, in_ready4}, 32'd1);
    tick();
    in_valid4 = 1'b0;
  endtask

  // Push a frame (optionally with random idle gaps), then time the SORT phase.
  task automatic frame4(input string tag, input bit gaps);
    int t;
    for (int i = 0; i < 4; i++) begin
      push4(d4[i]);
      if (gaps && i < 3) repeat ($urandom_range(0, 3)) tick();
    end
    check({tag, "_in_ready_after_fill"}, {31'd0, in_ready4}, 32'd0);
    check({tag, "_busy_after_fill"}, {31'd0, busy4}, 32'd1);
    sort_cyc4 = 0;
    t = 0;
    while (out_valid4 !== 1'b1 && t < 20) begin
      tick();
      sort_cyc4++;
      t++;
    end
  endtask

  task automatic drain4(input string tag, input bit alt, input int nbeats);
    int nb, t;
    bit rdy, ph;
    logic [7:0] ds;
    logic ls, vs;
    nb = 0;
    t  = 0;
    ph = 1'b1;
    while (nb < nbeats && t < 100) begin
      rdy = alt ? ph : 1'b1;
      ph  = ~ph;
      out_ready4 = rdy;
      ds = out_data4;
      ls = out_last4;
      vs = out_valid4;
      check({tag, "_out_valid"}, {31'd0, vs}, 32'd1);
      check({tag, "_in_ready_low"}, {31'd0, in_ready4}, 32'd0);
      tick();
      t++;
      if (vs && rdy) begin
        got4[nb] = ds;
        gl4[nb]  = ls;
        nb++;
      end else begin
        check({tag, "_stall_data"}, {24'd0, out_data4}, {24'd0, ds});
        check({tag, "_stall_last"}, {31'd0, out_last4}, {31'd0, ls});
      end
    end
    out_ready4 = 1'b0;
    check({tag, "_beats"}, nb, nbeats);
    if (nbeats == 4) begin
      check({tag, "_out_valid_after"}, {31'd0, out_valid4}, 32'd0);
      check({tag, "_in_ready_after"}, {31'd0, in_ready4}, 32'd1);
      check({tag, "_busy_after"}, {31'd0, busy4}, 32'd0);
    end
  endtask

  task automatic expect4(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_data%0d", tag, i), {24'd0, got4[i]}, {24'd0, e4[i]});
      check($sformatf("%s_last%0d", tag, i), {31'd0, gl4[i]}, (i == 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data4   = '0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    in_data5   = '0; in_valid5 = 1'b0; out_ready5 = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_in_ready", {31'd0, in_ready4}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid4}, 32'd0);
    check("rst_out_last", {31'd0, out_last4}, 32'd0);
    check("rst_busy", {31'd0, busy4}, 32'd0);
    check("rst_out_data", {24'd0, out_data4}, 32'd0);
    check("rst_in_ready5", {31'd0, in_ready5}, 32'd1);
    check("rst_busy5", {31'd0, busy5}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: reverse order, back-to-back, out_ready held high
    d4 = '{8'd3, 8'd2, 8'd1, 8'd0};
    frame4("t1", 1'b0);
    check("t1_sort_cycles", sort_cyc4, 32'd2);
    drain4("t1", 1'b0, 4);
    e4 = '{8'd0, 8'd1, 8'd2, 8'd3};
    expect4("t1");

    // 2: already sorted, one SORT cycle
    d4 = '{8'd5, 8'd10, 8'd15, 8'd20};
    frame4("t2", 1'b0);
    check("t2_sort_cycles", sort_cyc4, 32'd1);
    drain4("t2", 1'b0, 4);
    e4 = '{8'd5, 8'd10, 8'd15, 8'd20};
    expect4("t2");

    // 3: extremes with duplicates
    d4 = '{8'd255, 8'd0, 8'd255, 8'd0};
    frame4("t3", 1'b0);
    check("t3_sort_le4", {31'd0, (sort_cyc4 >= 1 && sort_cyc4 <= 4)}, 32'd1);
    drain4("t3", 1'b0, 4);
    e4 = '{8'd0, 8'd0, 8'd255, 8'd255};
    expect4("t3");

    // 4: input gaps and alternating out_ready
    d4 = '{8'd40, 8'd7, 8'd99, 8'd7};
    frame4("t4", 1'b1);
    check("t4_sort_cycles", sort_cyc4, 32'd2);
    drain4("t4", 1'b1, 4);
    e4 = '{8'd7, 8'd7, 8'd40, 8'd99};
    expect4("t4");

    // 5: reset after two output beats, then a clean frame
    d4 = '{8'd50, 8'd60, 8'd20, 8'd10};
    frame4("t5a", 1'b0);
    drain4("t5a", 1'b0, 2);
    check("t5a_beat0", {24'd0, got4[0]}, 32'd10);
    check("t5a_beat1", {24'd0, got4[1]}, 32'd20);
    rst_n = 1'b0;
    tick();
    check("t5_rst_out_valid", {31'd0, out_valid4}, 32'd0);
    check("t5_rst_in_ready", {31'd0, in_ready4}, 32'd1);
    check("t5_rst_busy", {31'd0, busy4}, 32'd0);
    rst_n = 1'b1;
    d4 = '{8'd9, 8'd8, 8'd7, 8'd6};
    frame4("t5b", 1'b0);
    drain4("t5b", 1'b0, 4);
    e4 = '{8'd6, 8'd7, 8'd8, 8'd9};
    expect4("t5b");

    // 6: DIM=5 random frames against an insertion-sort model
    for (int f = 0; f < 1000; f++) begin
      int t, nb, sc;
      bit srt, rdy;
      logic [7:0] tmp, ds;
      logic ls, vs;
      for (int i = 0; i < 5; i++) begin
        if (f % 50 == 0)     v5[i] = 8'(i * 13 + f % 7);
        else if (f % 2 == 0) v5[i] = 8'($urandom_range(0, 3));
        else                 v5[i] = 8'($urandom_range(0, 255));
        s5[i] = v5[i];
      end
      for (int i = 1; i < 5; i++) begin
        for (int j = i; j > 0; j--) begin
          if (s5[j-1] > s5[j]) begin
            tmp = s5[j-1]; s5[j-1] = s5[j]; s5[j] = tmp;
          end
        end
      end
      srt = 1'b1;
      for (int i = 0; i < 4; i++) if (v5[i] > v5[i+1]) srt = 1'b0;

      for (int i = 0; i < 5; i++) begin
        in_valid5 = 1'b1;
        in_data5  = v5[i];
        t = 0;
        while (in_ready5 !== 1'b1 && t < 50) begin tick(); t++; end
        if (t >= 50) check("t6_push_timeout", {31'd0, in_ready5}, 32'd1);
        tick();
      end
      in_valid5 = 1'b0;

      sc = 0;
      t  = 0;
      while (out_valid5 !== 1'b1 && t < 20) begin tick(); sc++; t++; end
      // A settled sort (no watchdog exit) takes 1 cycle if sorted, else 2.
      check("t6_sort_cycles", sc, srt ? 32'd1 : 32'd2);

      nb = 0;
      t  = 0;
      while (nb < 5 && t < 100) begin
        rdy = 1'($urandom_range(0, 1));
        out_ready5 = rdy;
        ds = out_data5; ls = out_last5; vs = out_valid5;
        tick();
        t++;
        if (vs && rdy) begin
          check($sformatf("t6_f%0d_data%0d", f, nb), {24'd0, ds}, {24'd0, s5[nb]});
          check($sformatf("t6_f%0d_last%0d", f, nb), {31'd0, ls}, (nb == 4) ? 32'd1 : 32'd0);
          nb++;
        end
      end
      out_ready5 = 1'b0;
      check("t6_beats", nb, 32'd5);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
